// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, key-length lookups, Rcon and S-box tables.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_BAD = 2'd3
    } key_len_e;

    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e len);
        case (len)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        return (idx <= 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_of(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_subword.sv
`default_nettype none
// ============================================================================
// Module      : aes_subword
// Description : AES SubWord - four parallel S-box lookups on one 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign o_word[8*b +: 8] = sbox_of(i_word[8*b +: 8]);
    end

endmodule : aes_subword
`default_nettype wire

// File: rtl/key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_seq
// Description : Sequential AES key expansion, one word per cycle, round keys
//               handed out over a valid/ready interface.
//               Define KEY_SCHED_AES256_EN to enable AES-256 key support.
// Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int MAX_NK  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [1:0]                      key_len,
    input  logic [MAX_NK-1:0][regSize-1:0]  key_in,
    output logic [vecSize-1:0][regSize-1:0] round_key,
    output logic                            rk_valid,
    input  logic                            rk_ready,
    output logic [3:0]                      rk_index,
    output logic                            rk_last,
    output logic                            busy,
    output logic                            err
);

`ifdef KEY_SCHED_AES256_EN
    localparam int c_WIN_DEPTH = MAX_NK;
`else
    localparam int c_WIN_DEPTH = (MAX_NK < 6) ? MAX_NK : 6;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_EXPAND  = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    state_e             r_state;
    key_len_e           r_len;
    logic [regSize-1:0] r_win [c_WIN_DEPTH];
    logic [2:0]         r_phase;
    logic [3:0]         r_div;
    logic [1:0]         r_wcnt;

    logic               w_len_legal;
    logic [3:0]         w_nk;
    logic [3:0]         w_nr;
    logic [2:0]         w_last_idx;
    logic [regSize-1:0] w_prev;
    logic [regSize-1:0] w_rot;
    logic [regSize-1:0] w_sub_in;
    logic [regSize-1:0] w_sub_out;
    logic [regSize-1:0] w_t;
    logic [regSize-1:0] w_word;
    logic [regSize-1:0] w_shift [c_WIN_DEPTH];

`ifdef KEY_SCHED_AES256_EN
    assign w_len_legal = (key_len != 2'd3);
`else
    assign w_len_legal = (key_len < 2'd2);
`endif

    if (MAX_NK > c_WIN_DEPTH) begin : g_unused_key
        logic [(MAX_NK-c_WIN_DEPTH)*regSize-1:0] w_unused_key;
        assign w_unused_key = key_in[MAX_NK-1:c_WIN_DEPTH];
    end

    // The window is a shift register: r_win[0] is w[i-Nk], r_win[Nk-1] is w[i-1].
    assign w_nk       = nk_of(r_len);
    assign w_nr       = nr_of(r_len);
    assign w_last_idx = 3'(w_nk - 4'd1);
    assign w_prev     = r_win[w_last_idx];
    assign w_rot      = {w_prev[regSize-9:0], w_prev[regSize-1:regSize-8]};

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_sub_in = (r_phase == 3'd0) ? w_rot : w_prev;
        w_t      = w_prev;
        if (r_phase == 3'd0) begin
            w_t = w_sub_out ^ {rcon_of(r_div), {(regSize-8){1'b0}}};
        end
`ifdef KEY_SCHED_AES256_EN
        else if (w_nk == 4'd8 && r_phase == 3'd4) begin
            w_t = w_sub_out;
        end
`endif
        // During the first Nk words the key simply rotates through the window.
        w_word = (r_div == 4'd0) ? r_win[0] : (r_win[0] ^ w_t);
        for (int k = 0; k < c_WIN_DEPTH - 1; k++) begin
            w_shift[k] = r_win[k+1];
        end
        w_shift[c_WIN_DEPTH-1] = w_word;
        w_shift[w_last_idx]    = w_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_len     <= KEY_128;
            r_phase   <= '0;
            r_div     <= '0;
            r_wcnt    <= '0;
            round_key <= '0;
            rk_valid  <= 1'b0;
            rk_index  <= '0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            for (int k = 0; k < c_WIN_DEPTH; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_len_legal) begin
                            r_len <= key_len_e'(key_len);
                            for (int k = 0; k < c_WIN_DEPTH; k++) begin
                                r_win[k] <= key_in[k];
                            end
                            busy    <= 1'b1;
                            r_state <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_phase  <= '0;
                    r_div    <= '0;
                    r_wcnt   <= '0;
                    rk_index <= '0;
                    rk_last  <= 1'b0;
                    r_state  <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    round_key[r_wcnt] <= w_word;
                    r_win             <= w_shift;
                    r_wcnt            <= r_wcnt + 2'd1;
                    if (r_phase == w_last_idx) begin
                        r_phase <= '0;
                        r_div   <= r_div + 4'd1;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                    if (r_wcnt == 2'd3) begin
                        rk_valid <= 1'b1;
                        rk_last  <= (rk_index == w_nr);
                        r_state  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_last) begin
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            rk_index <= rk_index + 4'd1;
                            r_state  <= ST_EXPAND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : key_schedule_seq
`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_schedule_seq
// Description : Self-checking bench for key_schedule_seq with a FIPS-197 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_seq;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             rk_ready;
    logic [1:0]       key_len;
    logic [7:0][31:0] key_in;
    logic [3:0][31:0] round_key;
    logic             rk_valid;
    logic [3:0]       rk_index;
    logic             rk_last;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    key_schedule_seq #(.regSize(32), .vecSize(4), .MAX_NK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .key_in    (key_in),
        .round_key (round_key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .rk_last   (rk_last),
        .busy      (busy),
        .err       (err)
    );

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t [0:255];
    logic [7:0]   rc_t   [0:10];
    logic [31:0]  mw     [0:59];
    int           nk_m = 4;
    int           nr_m = 10;
    bit           model_on = 1'b0;
    int           exp_r = 0;
    int           n_xfer = 0;
    int           last_idx = -1;
    logic [127:0] cap [0:14];
    logic [127:0] cmp_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) arithmetic used to derive the S-box from its definition.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_t[0] = 8'h00;
        rc_t[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc_t[j] = xt(rc_t[j-1]);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0][31:0] mk_key(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] rk_lit(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic model_load(input logic [7:0][31:0] k, input int len);
        logic [31:0] t;
        nk_m = 4 + 2 * len;
        nr_m = nk_m + 6;
        for (int i = 0; i < nk_m; i++) mw[i] = k[i];
        for (int i = nk_m; i < 4 * (nr_m + 1); i++) begin
            t = mw[i-1];
            if (i % nk_m == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rc_t[i / nk_m], 24'h0};
            else if (nk_m == 8 && i % 8 == 4)
                t = subw(t);
            mw[i] = mw[i-nk_m] ^ t;
        end
        for (int r = 0; r < 15; r++) cap[r] = '0;
        exp_r    = 0;
        n_xfer   = 0;
        last_idx = -1;
        model_on = 1'b1;
    endtask

    // Every cycle a round key is offered it must match the model's next round.
    always @(negedge clk) begin
        if (rst_n && rk_valid) begin
            if (!model_on) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rk_valid=1 index %0d expected rk_valid=0", rk_index);
            end else begin
                cmp_exp = {mw[4*exp_r+3], mw[4*exp_r+2], mw[4*exp_r+1], mw[4*exp_r]};
                check($sformatf("round_key[%0d]", exp_r), round_key, cmp_exp);
                check("rk_index", 128'(rk_index), 128'(exp_r));
                check("rk_last", 128'(rk_last), 128'(exp_r == nr_m));
                if (rk_ready) begin
                    cap[exp_r] = round_key;
                    if (rk_last) last_idx = int'(rk_index);
                    n_xfer++;
                    if (exp_r == nr_m) model_on = 1'b0;
                    exp_r++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_key(input logic [7:0][31:0] k, input int len);
        int n;
        model_load(k, len);
        key_in  = k;
        key_len = 2'(len);
        start   = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!rk_valid && n < 20) begin tick(); n++; end
        check("first_latency", 128'(n), 128'(5));
        while (busy && n < 2000) begin tick(); n++; end
        check("total_edges", 128'(n), 128'(1 + 5 * (nr_m + 1)));
    endtask

    task automatic reject_test(input logic [7:0][31:0] k, input logic [1:0] len);
        model_on = 1'b0;
        key_in   = k;
        key_len  = len;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("reject_err", 128'(err), 128'(1));
        check("reject_busy", 128'(busy), 128'(0));
        tick();
        check("reject_err_clear", 128'(err), 128'(0));
        check("reject_busy_idle", 128'(busy), 128'(0));
    endtask

    logic [7:0][31:0] k128, k192, k256;

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        rk_ready = 1'b1;
        k128 = mk_key(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0);
        k192 = mk_key(32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                      32'h62f8ead2, 32'h522c6b7b, 0, 0);
        k256 = mk_key(32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                      32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4);
        build_tables();

        #1 rst_n = 1'b0;
        #3;
        check("reset_round_key", round_key, 128'h0);
        check("reset_rk_valid", 128'(rk_valid), 128'(0));
        check("reset_rk_index", 128'(rk_index), 128'(0));
        check("reset_rk_last", 128'(rk_last), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_err", 128'(err), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_key('0, 0);
        check("zero_rk1", cap[1], rk_lit(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363));
        check("zero_xfers", 128'(n_xfer), 128'(11));
        check("zero_last_idx", 128'(last_idx), 128'(10));

        run_key(k128, 0);
        check("fips128_rk1", cap[1], rk_lit(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
        check("fips128_rk10", cap[10], rk_lit(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));

        run_key(k192, 1);
        check("fips192_rk12", cap[12], rk_lit(32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202));
        check("fips192_xfers", 128'(n_xfer), 128'(13));

`ifdef KEY_SCHED_AES256_EN
        run_key(k256, 2);
        check("fips256_rk14", cap[14], rk_lit(32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e));
        check("fips256_xfers", 128'(n_xfer), 128'(15));
`else
        reject_test(k256, 2'd2);
`endif
        reject_test(k128, 2'd3);

        // Back-pressure with a stray start while busy.
        model_load(k128, 0);
        rk_ready = 1'b0;
        key_in   = k128;
        key_len  = 2'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n = 0;
            while (!rk_valid && n < 20) begin tick(); n++; end
            check("stall_latency", 128'(n), 128'(5));
        end
        for (int c = 0; c < 7; c++) begin
            check("stall_valid", 128'(rk_valid), 128'(1));
            check("stall_round_key", round_key, {mw[3], mw[2], mw[1], mw[0]});
            check("stall_index", 128'(rk_index), 128'(0));
            check("stall_busy", 128'(busy), 128'(1));
            check("stall_err", 128'(err), 128'(0));
            if (c == 2) begin
                start   = 1'b1;
                key_len = 2'd3;
                key_in  = '0;
            end
            tick();
            start = 1'b0;
        end
        rk_ready = 1'b1;
        key_len  = 2'd0;
        begin
            int n = 0;
            while (busy && n < 2000) begin tick(); n++; end
        end
        check("stall_xfers", 128'(n_xfer), 128'(11));
        check("stall_rk10", cap[10], rk_lit(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));

        // Asynchronous reset in the middle of round 3.
        model_load(k128, 0);
        key_in  = k128;
        key_len = 2'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        begin
            int n = 0;
            while (n_xfer < 3 && n < 200) begin tick(); n++; end
            check("abort_reach_round3", 128'(n_xfer), 128'(3));
        end
        tick();
        tick();
        #2;
        model_on = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("abort_round_key", round_key, 128'h0);
        check("abort_rk_valid", 128'(rk_valid), 128'(0));
        check("abort_rk_index", 128'(rk_index), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_hold_valid", 128'(rk_valid), 128'(0));
        end
        rst_n = 1'b1;
        run_key(k128, 0);
        check("restart_rk1", cap[1], rk_lit(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
        check("restart_rk10", cap[10], rk_lit(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
        check("restart_xfers", 128'(n_xfer), 128'(11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_key_schedule_seq
`default_nettype wire
